data_write: RTL and testbench



---
 rtl/data_write.sv | 143 ++++++++++++++
 tb/tb_data_write.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/data_write.sv
// data_write: packs DATA_WIDTH-bit result words into LINE_WIDTH-bit lines and writes them to host memory.
// Ports: clk, rst (asynchronous, active-high); start/num_data begin a transfer of num_data words;
//        en_data/data_in/ready accept result words; available_write/req_wr_data/wr_data write one
//        line per strobe; done is raised once every line has been issued and held until next start.
// Optional: defining DATA_WRITE_COUNT_EN adds wr_count, the number of write strobes since the last start.
module data_write #(
    parameter int DATA_WIDTH     = 32,
    parameter int LINE_WIDTH     = 512,
    parameter int FIFO_DEPTH_LOG = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [31:0]           num_data,
    input  logic                  en_data,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ready,
    input  logic                  available_write,
    output logic                  req_wr_data,
    output logic [LINE_WIDTH-1:0] wr_data,
`ifdef DATA_WRITE_COUNT_EN
    output logic [31:0]           wr_count,
`endif
    output logic                  done
);
    localparam int WPL   = LINE_WIDTH / DATA_WIDTH;
    localparam int WIW   = (WPL > 1) ? $clog2(WPL) : 1;
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG;
    localparam int PW    = FIFO_DEPTH_LOG;
    localparam int CW    = FIFO_DEPTH_LOG + 1;
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2, DONE = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [31:0]           num_q, num_d, words_q, words_d;
    logic [WIW-1:0]        widx_q, widx_d;
    logic [LINE_WIDTH-1:0] pack_q, pack_d, line_q, line_d, wr_data_q, wr_data_d;
    logic                  push_q, push_d, done_q, done_d, req_q, req_d;
    logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [31:0]           wr_cnt_q, wr_cnt_d;
    logic [LINE_WIDTH-1:0] mem [DEPTH];
    logic                  fifo_full, accept, pop, last_w, fin, starting;
    logic [LINE_WIDTH-1:0] head;

    always_comb begin
        // A pending push counts as occupied so a completed line always finds a free slot.
        fifo_full = (32'(cnt_q) + 32'(push_q)) >= 32'(DEPTH);
        ready     = (state_q == RUN) && !fifo_full && (words_q < num_q);
        accept    = en_data && ready;
        // A line being pushed into an empty FIFO is forwarded straight to the write port.
        pop       = available_write && ((cnt_q != '0) || push_q);
        head      = (cnt_q != '0) ? mem[rptr_q] : line_q;
        starting  = ((state_q == IDLE) || (state_q == DONE)) && start;
        last_w    = widx_q == WIW'(WPL - 1);
        fin       = (words_q + 32'd1) == num_q;
        state_d   = state_q;
        num_d     = num_q;
        words_d   = words_q;
        widx_d    = widx_q;
        pack_d    = pack_q;
        line_d    = line_q;
        push_d    = 1'b0;
        done_d    = done_q;
        if (starting) begin
            num_d   = num_data;
            words_d = '0;
            widx_d  = '0;
            pack_d  = '0;
            done_d  = 1'b0;
            state_d = (num_data == 32'd0) ? FLUSH : RUN;
        end
        if (accept) begin
            pack_d[widx_q*DATA_WIDTH +: DATA_WIDTH] = data_in;
            words_d = words_q + 32'd1;
            widx_d  = last_w ? '0 : widx_q + 1'b1;
            if (last_w || fin) begin
                line_d = pack_d;
                pack_d = '0;
                widx_d = '0;
                push_d = 1'b1;
            end
            if (fin) state_d = FLUSH;
        end
        if ((state_q == FLUSH) && (cnt_q == '0) && !push_q) begin
            state_d = DONE;
            done_d  = 1'b1;
        end
        wptr_d    = wptr_q + PW'(push_q);
        rptr_d    = rptr_q + PW'(pop);
        cnt_d     = cnt_q + CW'(push_q) - CW'(pop);
        req_d     = pop;
        wr_data_d = pop ? head : wr_data_q;
        wr_cnt_d  = starting ? 32'd0 : wr_cnt_q + 32'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            num_q     <= '0;
            words_q   <= '0;
            widx_q    <= '0;
            pack_q    <= '0;
            line_q    <= '0;
            push_q    <= 1'b0;
            done_q    <= 1'b0;
            req_q     <= 1'b0;
            wr_data_q <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            wr_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            words_q   <= words_d;
            widx_q    <= widx_d;
            pack_q    <= pack_d;
            line_q    <= line_d;
            push_q    <= push_d;
            done_q    <= done_d;
            req_q     <= req_d;
            wr_data_q <= wr_data_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_q) mem[wptr_q] <= line_q;
    end

    assign req_wr_data = req_q;
    assign wr_data     = wr_data_q;
    assign done        = done_q;
`ifdef DATA_WRITE_COUNT_EN
    assign wr_count    = wr_cnt_q;
`else
    logic unused_wr_cnt;
    assign unused_wr_cnt = ^wr_cnt_q;
`endif
endmodule

// File: tb/tb_data_write.sv
// tb_data_write: randomized scoreboard bench for data_write; expected lines are queued at start, a monitor checks each strobe.
module tb_data_write;
    logic         clk = 1'b0, rst = 1'b1, start = 1'b0, en_data = 1'b0, available_write = 1'b0;
    logic [31:0]  num_data = '0, data_in = '0;
    logic         ready, req_wr_data, done;
    logic [511:0] wr_data;
`ifdef DATA_WRITE_COUNT_EN
    logic [31:0]  wr_count;
`endif
    int checks = 0, errors = 0, strobes = 0, av_mode = 0;
    logic [31:0]  words[$];
    logic [511:0] exp_q[$];
    logic [511:0] wr_log[$];

    data_write dut (
        .clk(clk), .rst(rst), .start(start), .num_data(num_data), .en_data(en_data),
        .data_in(data_in), .ready(ready), .available_write(available_write),
        .req_wr_data(req_wr_data), .wr_data(wr_data),
`ifdef DATA_WRITE_COUNT_EN
        .wr_count(wr_count),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        available_write = (av_mode == 2) ? 1'($urandom_range(0, 1)) : (av_mode == 1);
    end

    initial forever begin
        @(negedge clk);
        if (!rst && req_wr_data) begin
            strobes++;
            wr_log.push_back(wr_data);
            if (exp_q.size() == 0) check("unexpected_strobe", 512'(1), 512'(0));
            else check("line_data", wr_data, exp_q.pop_front());
        end
    end

    // Reference: words are cut into groups of 16, word k of a group at bits k*32, missing words zero.
    task automatic prep(input int n, input bit rnd, input logic [31:0] base);
        logic [511:0] line;
        words.delete();
        for (int i = 0; i < n; i++) words.push_back(rnd ? $urandom : base + 32'(i));
        for (int l = 0; l < (n + 15) / 16; l++) begin
            line = '0;
            for (int k = 0; k < 16; k++)
                if (l * 16 + k < n) line[k*32 +: 32] = words[l * 16 + k];
            exp_q.push_back(line);
        end
    endtask

    task automatic pulse_start(input int n);
        @(posedge clk);
        #1;
        start = 1'b1;
        num_data = 32'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
`ifdef DATA_WRITE_COUNT_EN
        check("wr_count_cleared", 512'(wr_count), 512'(0));
`endif
    endtask

    task automatic stream(input int from, input int upto, input bit gaps, input int stall_limit, output int got);
        int i = from;
        int stall = 0;
        bit acc;
        while (i < upto && stall < stall_limit) begin
            en_data = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            data_in = words[i];
            @(negedge clk);
            acc = en_data && ready;
            @(posedge clk);
            #1;
            if (acc) begin
                i++;
                stall = 0;
            end else stall++;
        end
        en_data = 1'b0;
        got = i;
    endtask

    task automatic finish_xfer(input int n, input int s0);
        int c = 0;
        while (!done && c < 3000) begin
            @(negedge clk);
            c++;
        end
        check("done", 512'(done), 512'(1));
        check("strobe_count", 512'(strobes - s0), 512'((n + 15) / 16));
        check("scoreboard_empty", 512'(exp_q.size()), 512'(0));
        check("ready_after_done", 512'(ready), 512'(0));
`ifdef DATA_WRITE_COUNT_EN
        check("wr_count_at_done", 512'(wr_count), 512'((n + 15) / 16));
`endif
    endtask

    task automatic run_xfer(input int n, input bit gaps, input bit rnd, input logic [31:0] base);
        int s0, got;
        prep(n, rnd, base);
        s0 = strobes;
        pulse_start(n);
        stream(0, n, gaps, 200, got);
        check("words_accepted", 512'(got), 512'(n));
        finish_xfer(n, s0);
    endtask

    initial begin
        int s0, got, b;
        logic [511:0] l0, l1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 512'(ready), 512'(0));
        check("rst_req", 512'(req_wr_data), 512'(0));
        check("rst_done", 512'(done), 512'(0));
        check("rst_wr_data", wr_data, 512'(0));
        rst = 1'b0;

        av_mode = 1;
        b = wr_log.size();
        run_xfer(32, 0, 0, 32'd0);
        l0 = wr_log[b];
        l1 = wr_log[b + 1];
        check("full_l0_lo", 512'(l0[31:0]), 512'(0));
        check("full_l0_hi", 512'(l0[511:480]), 512'(15));
        check("full_l1_lo", 512'(l1[31:0]), 512'(16));

        run_xfer(20, 0, 0, 32'h100);
        l1 = wr_log[wr_log.size() - 1];
        check("partial_lo", 512'(l1[127:0]), 512'({32'h113, 32'h112, 32'h111, 32'h110}));
        check("partial_hi", 512'(l1[511:128]), 512'(0));

        av_mode = 0;
        prep(96, 0, 32'h1000);
        s0 = strobes;
        pulse_start(96);
        stream(0, 96, 0, 20, got);
        check("bp_words_before_stall", 512'(got), 512'(64));
        @(negedge clk);
        check("bp_ready_low", 512'(ready), 512'(0));
        check("bp_no_strobes", 512'(strobes - s0), 512'(0));
        av_mode = 1;
        stream(got, 96, 0, 200, got);
        check("bp_words_total", 512'(got), 512'(96));
        finish_xfer(96, s0);

        prep(0, 0, 32'd0);
        s0 = strobes;
        pulse_start(0);
        @(negedge clk);
        check("zero_done_early", 512'(done), 512'(0));
        check("zero_ready", 512'(ready), 512'(0));
        @(negedge clk);
        check("zero_done_2cyc", 512'(done), 512'(1));
        check("zero_strobes", 512'(strobes - s0), 512'(0));

        prep(48, 0, 32'h2000);
        pulse_start(48);
        stream(0, 20, 0, 200, got);
        check("mid_words", 512'(got), 512'(20));
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_ready", 512'(ready), 512'(0));
        check("mid_rst_req", 512'(req_wr_data), 512'(0));
        check("mid_rst_done", 512'(done), 512'(0));
        check("mid_rst_wr_data", wr_data, 512'(0));
`ifdef DATA_WRITE_COUNT_EN
        check("mid_rst_wr_count", 512'(wr_count), 512'(0));
`endif
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_xfer(16, 0, 0, 32'h3000);

        av_mode = 2;
        run_xfer(40, 1, 1, 32'd0);
        for (int t = 0; t < 8; t++) run_xfer($urandom_range(0, 70), 1, 1, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
